// File: rtl/ram_arbiter_if.sv
// Bundle of requester-side and RAM-side signals shared by the arbiter and its users.
// The slave modport is the arbiter's view; master is the view of everything around it.
interface ram_arbiter_if #(
   parameter int CHANNELS = 2,
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 32
);
   logic [CHANNELS-1:0]        req_ce_i;
   logic [CHANNELS-1:0]        req_we_i;
   logic [4*CHANNELS-1:0]      req_sel_i;
   logic [ADDR_W*CHANNELS-1:0] req_addr_i;
   logic [DATA_W*CHANNELS-1:0] req_data_i;
   logic [DATA_W-1:0]          resp_data_o;
   logic [CHANNELS-1:0]        resp_ready_o;
   logic [CHANNELS-1:0]        resp_err_o;
   logic [ADDR_W-1:0]          ram_addr_o;
   logic                       ram_we_o;
   logic [3:0]                 ram_sel_o;
   logic [DATA_W-1:0]          ram_data_o;
   logic                       ram_ce_o;
   logic [DATA_W-1:0]          ram_data_i;
   logic                       ram_ready_i;
   logic [CHANNELS-1:0]        grant_o;

   modport slave (
      input  req_ce_i, req_we_i, req_sel_i, req_addr_i, req_data_i,
      input  ram_data_i, ram_ready_i,
      output resp_data_o, resp_ready_o, resp_err_o,
      output ram_addr_o, ram_we_o, ram_sel_o, ram_data_o, ram_ce_o, grant_o
   );

   modport master (
      output req_ce_i, req_we_i, req_sel_i, req_addr_i, req_data_i,
      output ram_data_i, ram_ready_i,
      input  resp_data_o, resp_ready_o, resp_err_o,
      input  ram_addr_o, ram_we_o, ram_sel_o, ram_data_o, ram_ce_o, grant_o
   );
endinterface

// File: rtl/ram_arbiter.sv
// Multi-channel arbiter sharing one RAM port: IDLE picks a winner, BUSY holds the
// latched request until ready or timeout, DONE is a one-cycle guard before re-arbitration.
module ram_arbiter #(
   parameter int CHANNELS = 2,
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 32,
   parameter int RR_MODE  = 0,
   parameter int TIMEOUT  = 255
) (
   input  logic           clk,
   input  logic           rst,
   ram_arbiter_if.slave   bus
);
   localparam int IDX_W = $clog2(CHANNELS);
   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t              state_reg;
   logic [IDX_W-1:0]    owner_reg;
   logic [IDX_W-1:0]    last_grant_reg;
   logic [CNT_W-1:0]    cnt_reg;
   logic [CHANNELS-1:0] grant_reg;
   logic [CHANNELS-1:0] resp_ready_reg;
   logic [CHANNELS-1:0] resp_err_reg;
   logic [DATA_W-1:0]   resp_data_reg;
   logic [ADDR_W-1:0]   ram_addr_reg;
   logic                ram_we_reg;
   logic [3:0]          ram_sel_reg;
   logic [DATA_W-1:0]   ram_data_reg;
   logic                ram_ce_reg;

   logic [IDX_W-1:0]    win_idx;
   logic                win_found;
   int                  cand;

   logic [3:0]          sel_arr   [CHANNELS];
   logic [ADDR_W-1:0]   addr_arr  [CHANNELS];
   logic [DATA_W-1:0]   wdata_arr [CHANNELS];

   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_unpack
         assign sel_arr[gi]   = bus.req_sel_i[4*gi +: 4];
         assign addr_arr[gi]  = bus.req_addr_i[ADDR_W*gi +: ADDR_W];
         assign wdata_arr[gi] = bus.req_data_i[DATA_W*gi +: DATA_W];
      end
   endgenerate

   // Round-robin starts the scan one past the previous owner; fixed mode starts at 0.
   always_comb begin
      win_idx   = '0;
      win_found = 1'b0;
      cand      = 0;
      for (int i = 0; i < CHANNELS; i++) begin
         cand = (RR_MODE != 0) ? (int'(last_grant_reg) + 1 + i) % CHANNELS : i;
         if (!win_found && bus.req_ce_i[cand]) begin
            win_found = 1'b1;
            win_idx   = IDX_W'(cand);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= IDLE;
         owner_reg      <= '0;
         last_grant_reg <= IDX_W'(CHANNELS - 1);
         cnt_reg        <= '0;
         grant_reg      <= '0;
         resp_ready_reg <= '0;
         resp_err_reg   <= '0;
         resp_data_reg  <= '0;
         ram_addr_reg   <= '0;
         ram_we_reg     <= 1'b0;
         ram_sel_reg    <= '0;
         ram_data_reg   <= '0;
         ram_ce_reg     <= 1'b0;
      end else begin
         resp_ready_reg <= '0;
         resp_err_reg   <= '0;
         case (state_reg)
            IDLE: begin
               if (win_found) begin
                  owner_reg      <= win_idx;
                  last_grant_reg <= win_idx;
                  grant_reg      <= CHANNELS'(1) << win_idx;
                  ram_addr_reg   <= addr_arr[win_idx];
                  ram_we_reg     <= bus.req_we_i[win_idx];
                  ram_sel_reg    <= sel_arr[win_idx];
                  ram_data_reg   <= wdata_arr[win_idx];
                  ram_ce_reg     <= 1'b1;
                  cnt_reg        <= '0;
                  state_reg      <= BUSY;
               end
            end
            BUSY: begin
               cnt_reg <= cnt_reg + 1'b1;
               // Ready is checked first so a simultaneous timeout never reports an error.
               if (bus.ram_ready_i) begin
                  resp_data_reg             <= bus.ram_data_i;
                  resp_ready_reg[owner_reg] <= 1'b1;
                  ram_ce_reg                <= 1'b0;
                  state_reg                 <= DONE;
               end else if ((TIMEOUT > 0) && (cnt_reg == TMO_LAST)) begin
                  resp_err_reg[owner_reg] <= 1'b1;
                  ram_ce_reg              <= 1'b0;
                  state_reg               <= DONE;
               end
            end
            DONE: begin
               grant_reg <= '0;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.grant_o      = grant_reg;
   assign bus.resp_ready_o = resp_ready_reg;
   assign bus.resp_err_o   = resp_err_reg;
   assign bus.resp_data_o  = resp_data_reg;
   assign bus.ram_addr_o   = ram_addr_reg;
   assign bus.ram_we_o     = ram_we_reg;
   assign bus.ram_sel_o    = ram_sel_reg;
   assign bus.ram_data_o   = ram_data_reg;
   assign bus.ram_ce_o     = ram_ce_reg;
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a per-cycle vector table for fixed-priority traffic,
// then hand-written sequences for write latching, timeout, round-robin and mid-transfer reset.
module tb_ram_arbiter;
   logic clk;
   logic rst_a;
   logic rst_b;
   int   pass_cnt;
   int   total_cnt;

   ram_arbiter_if #(.CHANNELS(2), .DATA_W(32), .ADDR_W(32)) ia ();
   ram_arbiter_if #(.CHANNELS(4), .DATA_W(32), .ADDR_W(32)) ib ();

   ram_arbiter #(.CHANNELS(2), .DATA_W(32), .ADDR_W(32), .RR_MODE(0), .TIMEOUT(8)) dut_a (
      .clk (clk),
      .rst (rst_a),
      .bus (ia)
   );

   ram_arbiter #(.CHANNELS(4), .DATA_W(32), .ADDR_W(32), .RR_MODE(1), .TIMEOUT(0)) dut_b (
      .clk (clk),
      .rst (rst_b),
      .bus (ib)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  ce;
      logic        rdy;
      logic [31:0] rdata;
      logic [1:0]  e_grant;
      logic        e_ce;
      logic [1:0]  e_rr;
      logic [1:0]  e_err;
      logic [31:0] e_data;
      logic [31:0] e_addr;
   } vec_t;

   vec_t vt [17];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) begin
         pass_cnt++;
         $display("ok   %s: got %0h", name, act);
      end else begin
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int busy;
      logic [3:0] rr_exp [5];

      pass_cnt  = 0;
      total_cnt = 0;
      rst_a = 1'b0;
      rst_b = 1'b0;
      ia.req_ce_i    = '0;
      ia.req_we_i    = '0;
      ia.req_sel_i   = 8'hFF;
      ia.req_addr_i  = {32'h0000_0100, 32'h0000_0040};
      ia.req_data_i  = '0;
      ia.ram_data_i  = 32'hA5A5_A5A5;
      ia.ram_ready_i = 1'b0;
      ib.req_ce_i    = '0;
      ib.req_we_i    = '0;
      ib.req_sel_i   = 16'hFFFF;
      ib.req_addr_i  = {32'h30, 32'h20, 32'h10, 32'h00};
      ib.req_data_i  = '0;
      ib.ram_data_i  = 32'h0;
      ib.ram_ready_i = 1'b0;

      // ce, rdy, rdata, exp grant, exp ram_ce, exp resp_ready, exp err, exp resp_data, exp addr
      vt[0]  = '{2'b10, 1'b0, 32'hA5A5A5A5, 2'b10, 1'b1, 2'b00, 2'b00, 32'h0,        32'h100};
      vt[1]  = '{2'b10, 1'b0, 32'hA5A5A5A5, 2'b10, 1'b1, 2'b00, 2'b00, 32'h0,        32'h100};
      vt[2]  = '{2'b10, 1'b0, 32'hA5A5A5A5, 2'b10, 1'b1, 2'b00, 2'b00, 32'h0,        32'h100};
      vt[3]  = '{2'b10, 1'b1, 32'hDEADBEEF, 2'b10, 1'b0, 2'b10, 2'b00, 32'hDEADBEEF, 32'h0};
      vt[4]  = '{2'b00, 1'b0, 32'hA5A5A5A5, 2'b00, 1'b0, 2'b00, 2'b00, 32'hDEADBEEF, 32'h0};
      vt[5]  = '{2'b11, 1'b0, 32'hA5A5A5A5, 2'b01, 1'b1, 2'b00, 2'b00, 32'hDEADBEEF, 32'h40};
      vt[6]  = '{2'b11, 1'b1, 32'h11111111, 2'b01, 1'b0, 2'b01, 2'b00, 32'h11111111, 32'h0};
      vt[7]  = '{2'b10, 1'b0, 32'hA5A5A5A5, 2'b00, 1'b0, 2'b00, 2'b00, 32'h11111111, 32'h0};
      vt[8]  = '{2'b10, 1'b0, 32'hA5A5A5A5, 2'b10, 1'b1, 2'b00, 2'b00, 32'h11111111, 32'h100};
      vt[9]  = '{2'b11, 1'b1, 32'h22222222, 2'b10, 1'b0, 2'b10, 2'b00, 32'h22222222, 32'h0};
      vt[10] = '{2'b01, 1'b0, 32'hA5A5A5A5, 2'b00, 1'b0, 2'b00, 2'b00, 32'h22222222, 32'h0};
      vt[11] = '{2'b01, 1'b0, 32'hA5A5A5A5, 2'b01, 1'b1, 2'b00, 2'b00, 32'h22222222, 32'h40};
      vt[12] = '{2'b11, 1'b1, 32'h33333333, 2'b01, 1'b0, 2'b01, 2'b00, 32'h33333333, 32'h0};
      vt[13] = '{2'b11, 1'b0, 32'hA5A5A5A5, 2'b00, 1'b0, 2'b00, 2'b00, 32'h33333333, 32'h0};
      vt[14] = '{2'b11, 1'b0, 32'hA5A5A5A5, 2'b01, 1'b1, 2'b00, 2'b00, 32'h33333333, 32'h40};
      vt[15] = '{2'b11, 1'b1, 32'h44444444, 2'b01, 1'b0, 2'b01, 2'b00, 32'h44444444, 32'h0};
      vt[16] = '{2'b00, 1'b0, 32'hA5A5A5A5, 2'b00, 1'b0, 2'b00, 2'b00, 32'h44444444, 32'h0};

      rr_exp[0] = 4'b0001;
      rr_exp[1] = 4'b0010;
      rr_exp[2] = 4'b0100;
      rr_exp[3] = 4'b1000;
      rr_exp[4] = 4'b0001;

      // Reset state
      step();
      step();
      chk("rst_a grant", ia.grant_o, 2'b00);
      chk("rst_a ram_ce", ia.ram_ce_o, 1'b0);
      chk("rst_a resp", {ia.resp_ready_o, ia.resp_err_o, ia.resp_data_o}, 36'h0);
      chk("rst_a ram_bus", {ia.ram_addr_o, ia.ram_we_o, ia.ram_sel_o, ia.ram_data_o}, 69'h0);
      chk("rst_b grant", ib.grant_o, 4'b0000);
      rst_a = 1'b1;
      rst_b = 1'b1;
      step();

      // Fixed-priority vectors: single read then two-channel contention
      for (int i = 0; i < 17; i++) begin
         ia.req_ce_i    = vt[i].ce;
         ia.ram_ready_i = vt[i].rdy;
         ia.ram_data_i  = vt[i].rdata;
         step();
         chk($sformatf("v%0d grant", i), ia.grant_o, vt[i].e_grant);
         chk($sformatf("v%0d ram_ce", i), ia.ram_ce_o, vt[i].e_ce);
         chk($sformatf("v%0d resp_ready", i), ia.resp_ready_o, vt[i].e_rr);
         chk($sformatf("v%0d resp_err", i), ia.resp_err_o, vt[i].e_err);
         chk($sformatf("v%0d resp_data", i), ia.resp_data_o, vt[i].e_data);
         if (vt[i].e_ce)
            chk($sformatf("v%0d ram_addr", i), ia.ram_addr_o, vt[i].e_addr);
      end

      // Write latch: requester changes data and drops ce right after grant
      ia.ram_ready_i = 1'b0;
      ia.req_data_i  = {32'h0, 32'h1234_5678};
      ia.req_sel_i   = 8'h0F;
      ia.req_we_i    = 2'b01;
      ia.req_ce_i    = 2'b01;
      step();
      chk("wr grant", ia.grant_o, 2'b01);
      chk("wr latch", {ia.ram_we_o, ia.ram_sel_o, ia.ram_data_o, ia.ram_addr_o}, {1'b1, 4'hF, 32'h1234_5678, 32'h40});
      ia.req_data_i = {32'h0, 32'hCAFE_F00D};
      ia.req_sel_i  = 8'h00;
      ia.req_we_i   = 2'b00;
      ia.req_ce_i   = 2'b00;
      for (int n = 0; n < 2; n++) begin
         step();
         chk($sformatf("wr hold%0d", n), {ia.ram_ce_o, ia.ram_we_o, ia.ram_sel_o, ia.ram_data_o}, {1'b1, 1'b1, 4'hF, 32'h1234_5678});
      end
      ia.ram_ready_i = 1'b1;
      ia.ram_data_i  = 32'h5A5A_0001;
      step();
      chk("wr resp_ready", ia.resp_ready_o, 2'b01);
      chk("wr resp_data", ia.resp_data_o, 32'h5A5A_0001);
      ia.ram_ready_i = 1'b0;
      ia.ram_data_i  = 32'hA5A5_A5A5;
      step();

      // Timeout with ram_ready never asserted
      ia.req_ce_i = 2'b01;
      step();
      ia.req_ce_i = 2'b00;
      busy = ia.ram_ce_o ? 1 : 0;
      for (int n = 0; n < 20; n++) begin
         step();
         if (ia.ram_ce_o) busy++;
         else break;
      end
      chk("tmo busy cycles", busy, 8);
      chk("tmo err", ia.resp_err_o, 2'b01);
      chk("tmo ready", ia.resp_ready_o, 2'b00);
      chk("tmo data kept", ia.resp_data_o, 32'h5A5A_0001);
      step();
      chk("tmo idle grant", ia.grant_o, 2'b00);
      chk("tmo err pulse", ia.resp_err_o, 2'b00);

      // Ready arrives in the 8th BUSY cycle: ready must win over timeout
      ia.req_ce_i = 2'b01;
      step();
      chk("tmo2 grant", ia.grant_o, 2'b01);
      ia.req_ce_i = 2'b00;
      for (int n = 0; n < 7; n++) step();
      chk("tmo2 still busy", ia.ram_ce_o, 1'b1);
      ia.ram_ready_i = 1'b1;
      ia.ram_data_i  = 32'h0000_0055;
      step();
      chk("tmo2 ready", ia.resp_ready_o, 2'b01);
      chk("tmo2 no err", ia.resp_err_o, 2'b00);
      chk("tmo2 data", ia.resp_data_o, 32'h0000_0055);
      ia.ram_ready_i = 1'b0;
      step();

      // Round-robin with all four channels requesting continuously
      ib.req_ce_i = 4'hF;
      for (int k = 0; k < 5; k++) begin
         ib.ram_ready_i = 1'b0;
         step();
         chk($sformatf("rr%0d grant", k), ib.grant_o, rr_exp[k]);
         ib.ram_ready_i = 1'b1;
         ib.ram_data_i  = 32'(k + 1);
         step();
         chk($sformatf("rr%0d resp_ready", k), ib.resp_ready_o, rr_exp[k]);
         ib.ram_ready_i = 1'b0;
         step();
      end

      // Reset in the 2nd BUSY cycle of a write
      ib.req_ce_i = 4'b0100;
      ib.req_we_i = 4'b0100;
      step();
      chk("rstw grant", ib.grant_o, 4'b0100);
      ib.req_ce_i = 4'b0000;
      ib.req_we_i = 4'b0000;
      step();
      #2;
      rst_b = 1'b0;
      #1;
      chk("rstw ram_ce", ib.ram_ce_o, 1'b0);
      chk("rstw grant0", ib.grant_o, 4'b0000);
      step();
      rst_b = 1'b1;
      for (int n = 0; n < 3; n++) begin
         step();
         chk($sformatf("rstw no pulse%0d", n), {ib.resp_ready_o, ib.resp_err_o}, 8'h00);
      end
      ib.req_ce_i = 4'hF;
      step();
      chk("rstw next ch0", ib.grant_o, 4'b0001);
      ib.req_ce_i = 4'h0;
      step();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
